// File: rtl/tiny_stage_feeder.sv
// tiny_stage_feeder: buffers A/B operand words for one tiny_glut row and
// replays them as valid-only beats. The block also keeps stage_start high
// through a drain window so results can leave the row.

// One circular operand FIFO. The head word is always visible on head.
module tiny_stage_feeder_fifo #(
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [63:0]   wr_data,
    input  logic          rd_en,
    output logic [63:0]   head,
    output logic [LW-1:0] count,
    output logic          drop
);
    localparam int AW = $clog2(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          wr_ok;

    // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
    assign full  = (count == LW'(DEPTH));
    assign wr_ok = wr_en && (!full || rd_en);
    assign drop  = wr_en && full && !rd_en;
    assign head  = mem[rd_ptr];

    // Storage array; it has no reset because the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH. The count tracks simultaneous push and pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module tiny_stage_feeder #(
    parameter int DEPTH = 16,
    parameter int DRAIN = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_wr_en,
    input  logic [63:0]   a_wr_data,
    output logic [LW-1:0] a_count,
    input  logic          b_wr_en,
    input  logic [63:0]   b_wr_data,
    output logic [LW-1:0] b_count,
    input  logic          cmd_valid,
    input  logic [LW-1:0] cmd_len,
    output logic          cmd_ready,
    output logic          stage_start,
    output logic          east_out_tvalid,
    output logic [63:0]   east_out_tdata,
    output logic          north_out_tvalid,
    output logic [63:0]   north_out_tdata,
    output logic          busy,
    output logic          done,
    output logic          ovf
);
    localparam logic [7:0]    DRAIN_CYC = 8'(DRAIN);
    localparam logic [LW-1:0] MAX_LEN   = LW'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SEND,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t        state;
    logic [LW-1:0] len;
    logic [LW-1:0] beat_cnt;
    logic [7:0]    drain_cnt;
    logic          go;
    logic          pop;
    logic [63:0]   a_head;
    logic [63:0]   b_head;
    logic          a_drop;
    logic          b_drop;

    // A beat is issued when WAIT hands over to SEND, and on every SEND cycle until len beats are out.
    assign pop = ((state == ST_WAIT) && go) || ((state == ST_SEND) && (beat_cnt < len));

    tiny_stage_feeder_fifo #(.DEPTH(DEPTH), .LW(LW)) u_fifo_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (a_wr_en),
        .wr_data (a_wr_data),
        .rd_en   (pop),
        .head    (a_head),
        .count   (a_count),
        .drop    (a_drop)
    );

    tiny_stage_feeder_fifo #(.DEPTH(DEPTH), .LW(LW)) u_fifo_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (b_wr_en),
        .wr_data (b_wr_data),
        .rd_en   (pop),
        .head    (b_head),
        .count   (b_count),
        .drop    (b_drop)
    );

    // Sticky overflow flag. Only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (a_drop || b_drop) begin
            ovf <= 1'b1;
        end
    end

    // Burst sequencer; every output is registered together with the state it belongs to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            len              <= '0;
            beat_cnt         <= '0;
            drain_cnt        <= '0;
            go               <= 1'b0;
            cmd_ready        <= 1'b1;
            busy             <= 1'b0;
            done             <= 1'b0;
            stage_start      <= 1'b0;
            east_out_tvalid  <= 1'b0;
            east_out_tdata   <= '0;
            north_out_tvalid <= 1'b0;
            north_out_tdata  <= '0;
        end else begin
            done             <= 1'b0;
            east_out_tvalid  <= 1'b0;
            east_out_tdata   <= '0;
            north_out_tvalid <= 1'b0;
            north_out_tdata  <= '0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        len       <= (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
                        go        <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_len == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    go <= (a_count >= len) && (b_count >= len);
                    if (go) begin
                        state            <= ST_SEND;
                        beat_cnt         <= LW'(1);
                        stage_start      <= 1'b1;
                        east_out_tvalid  <= 1'b1;
                        east_out_tdata   <= a_head;
                        north_out_tvalid <= 1'b1;
                        north_out_tdata  <= b_head;
                    end
                end
                ST_SEND: begin
                    stage_start <= 1'b1;
                    if (beat_cnt < len) begin
                        beat_cnt         <= beat_cnt + 1'b1;
                        east_out_tvalid  <= 1'b1;
                        east_out_tdata   <= a_head;
                        north_out_tvalid <= 1'b1;
                        north_out_tdata  <= b_head;
                    end else begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 8'd1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt < DRAIN_CYC) begin
                        drain_cnt   <= drain_cnt + 8'd1;
                        stage_start <= 1'b1;
                    end else begin
                        state       <= ST_DONE;
                        stage_start <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state       <= ST_IDLE;
                    cmd_ready   <= 1'b1;
                    busy        <= 1'b0;
                    stage_start <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tiny_stage_feeder.sv
// Testbench for tiny_stage_feeder. A queue model of both FIFOs serves as the
// scoreboard, and a negedge monitor checks every emitted beat against it.
module tb_tiny_stage_feeder;
    localparam int DEPTH = 16;
    localparam int DRAIN = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_wr_en = 1'b0;
    logic [63:0]   a_wr_data = '0;
    logic [LW-1:0] a_count;
    logic          b_wr_en = 1'b0;
    logic [63:0]   b_wr_data = '0;
    logic [LW-1:0] b_count;
    logic          cmd_valid = 1'b0;
    logic [LW-1:0] cmd_len = '0;
    logic          cmd_ready;
    logic          stage_start;
    logic          east_out_tvalid;
    logic [63:0]   east_out_tdata;
    logic          north_out_tvalid;
    logic [63:0]   north_out_tdata;
    logic          busy;
    logic          done;
    logic          ovf;

    logic [63:0] exp_a [$];
    logic [63:0] exp_b [$];
    logic        exp_ovf = 1'b0;
    int          tests = 0;
    int          failures = 0;
    int          beat_seen = 0;
    int          done_seen = 0;
    int          run_len = 0;
    int          last_run = 0;

    always #5 clk = ~clk;

    tiny_stage_feeder #(.DEPTH(DEPTH), .DRAIN(DRAIN), .LW(LW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .a_wr_en          (a_wr_en),
        .a_wr_data        (a_wr_data),
        .a_count          (a_count),
        .b_wr_en          (b_wr_en),
        .b_wr_data        (b_wr_data),
        .b_count          (b_count),
        .cmd_valid        (cmd_valid),
        .cmd_len          (cmd_len),
        .cmd_ready        (cmd_ready),
        .stage_start      (stage_start),
        .east_out_tvalid  (east_out_tvalid),
        .east_out_tdata   (east_out_tdata),
        .north_out_tvalid (north_out_tvalid),
        .north_out_tdata  (north_out_tdata),
        .busy             (busy),
        .done             (done),
        .ovf              (ovf)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of FIFO writes; the model keeps words that fit and flags an overflow otherwise.
    task automatic applyStimulus(input logic a_en, input logic [63:0] a_data,
                                 input logic b_en, input logic [63:0] b_data);
        a_wr_en   = a_en;
        a_wr_data = a_data;
        b_wr_en   = b_en;
        b_wr_data = b_data;
        if (a_en) begin
            if (exp_a.size() < DEPTH) exp_a.push_back(a_data);
            else exp_ovf = 1'b1;
        end
        if (b_en) begin
            if (exp_b.size() < DEPTH) exp_b.push_back(b_data);
            else exp_ovf = 1'b1;
        end
        tick();
        a_wr_en = 1'b0;
        b_wr_en = 1'b0;
    endtask

    task automatic issueCommand(input int len);
        cmd_valid = 1'b1;
        cmd_len   = LW'(len);
        tick();
        cmd_valid = 1'b0;
        cmd_len   = '0;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checkOutput("done_within_budget", 64'(done), 64'd1);
    endtask

    task automatic clearStats();
        beat_seen = 0;
        done_seen = 0;
        run_len   = 0;
        last_run  = 0;
    endtask

    // Beat monitor: compares every beat with the scoreboard and measures the stage_start window.
    always @(negedge clk) begin
        if (east_out_tvalid || north_out_tvalid) begin
            beat_seen++;
            checkOutput("valid_pair", 64'(north_out_tvalid), 64'(east_out_tvalid));
            checkOutput("sb_has_entry", 64'(exp_a.size() > 0 && exp_b.size() > 0), 64'd1);
            if (exp_a.size() > 0) checkOutput("east_data", east_out_tdata, exp_a.pop_front());
            if (exp_b.size() > 0) checkOutput("north_data", north_out_tdata, exp_b.pop_front());
        end else if (rst_n) begin
            checkOutput("idle_data", east_out_tdata | north_out_tdata, 64'd0);
        end
        if (stage_start) begin
            run_len++;
        end else if (run_len > 0) begin
            last_run = run_len;
            run_len  = 0;
        end
        if (done) done_seen++;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tick();
        tick();
        checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_stage", 64'(stage_start), 64'd0);
        checkOutput("rst_counts", 64'(a_count) + 64'(b_count), 64'd0);
        checkOutput("rst_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic len=4 burst with lane-replicated operands.
        for (int k = 1; k <= 4; k++)
            applyStimulus(1'b1, {4{16'(k)}}, 1'b1, {4{16'(k << 8)}});
        checkOutput("t1_a_count", 64'(a_count), 64'd4);
        checkOutput("t1_b_count", 64'(b_count), 64'd4);
        clearStats();
        issueCommand(4);
        checkOutput("t1_ready_low", 64'(cmd_ready), 64'd0);
        checkOutput("t1_busy", 64'(busy), 64'd1);
        tick();
        checkOutput("t1_no_beat_e1", 64'(east_out_tvalid), 64'd0);
        tick();
        checkOutput("t1_first_beat", 64'(east_out_tvalid), 64'd1);
        checkOutput("t1_first_stage", 64'(stage_start), 64'd1);
        waitDone(40);
        checkOutput("t1_ready_at_done", 64'(cmd_ready), 64'd0);
        tick();
        checkOutput("t1_done_pulse", 64'(done), 64'd0);
        checkOutput("t1_ready_back", 64'(cmd_ready), 64'd1);
        checkOutput("t1_stage_len", 64'(last_run), 64'(4 + DRAIN));
        checkOutput("t1_beats", 64'(beat_seen), 64'd4);
        checkOutput("t1_done_count", 64'(done_seen), 64'd1);
        checkOutput("t1_counts_zero", 64'(a_count) + 64'(b_count), 64'd0);

        // len=3 with empty FIFOs: the burst waits for the third B word.
        clearStats();
        issueCommand(3);
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, 64'hA0 + 64'(k), 1'b0, '0);
        repeat (4) tick();
        issueCommand(0);
        checkOutput("t2_ignored_cmd", 64'(done), 64'd0);
        checkOutput("t2_wait_busy", 64'(busy), 64'd1);
        for (int k = 0; k < 3; k++) begin
            checkOutput("t2_stage_wait", 64'(stage_start), 64'd0);
            applyStimulus(1'b0, '0, 1'b1, 64'hB0 + 64'(k));
        end
        checkOutput("t2_no_beats_yet", 64'(beat_seen), 64'd0);
        tick();
        checkOutput("t2_stage_still_low", 64'(stage_start), 64'd0);
        tick();
        checkOutput("t2_beat_after_b", 64'(east_out_tvalid), 64'd1);
        waitDone(40);
        tick();
        checkOutput("t2_beats", 64'(beat_seen), 64'd3);
        checkOutput("t2_stage_len", 64'(last_run), 64'(3 + DRAIN));
        checkOutput("t2_done_count", 64'(done_seen), 64'd1);

        // len=0: immediate done, no stage, counts untouched.
        for (int k = 0; k < 2; k++)
            applyStimulus(1'b1, 64'hC0 + 64'(k), 1'b1, 64'hD0 + 64'(k));
        clearStats();
        issueCommand(0);
        checkOutput("t3_done", 64'(done), 64'd1);
        checkOutput("t3_stage", 64'(stage_start), 64'd0);
        tick();
        checkOutput("t3_ready_back", 64'(cmd_ready), 64'd1);
        checkOutput("t3_a_count", 64'(a_count), 64'd2);
        checkOutput("t3_b_count", 64'(b_count), 64'd2);
        checkOutput("t3_no_beats", 64'(beat_seen), 64'd0);
        checkOutput("t3_no_stage", 64'(last_run + run_len), 64'd0);
        issueCommand(2);
        waitDone(40);
        tick();
        checkOutput("t3_drain_beats", 64'(beat_seen), 64'd2);

        // Overflow: 17 writes into A; then an over-long command is clamped to DEPTH.
        for (int k = 0; k < 17; k++) begin
            if (k == 16) checkOutput("t4_ovf_before", 64'(ovf), 64'd0);
            applyStimulus(1'b1, {32'hAAAA_0000, 32'(k)}, 1'b0, '0);
        end
        checkOutput("t4_a_count", 64'(a_count), 64'd16);
        checkOutput("t4_model_count", 64'(a_count), 64'(exp_a.size()));
        checkOutput("t4_ovf", 64'(ovf), 64'(exp_ovf));
        for (int k = 0; k < 16; k++)
            applyStimulus(1'b0, '0, 1'b1, {32'hBBBB_0000, 32'(k)});
        clearStats();
        issueCommand(20);
        waitDone(80);
        tick();
        checkOutput("t4_beats", 64'(beat_seen), 64'd16);
        checkOutput("t4_counts_zero", 64'(a_count) + 64'(b_count), 64'd0);
        checkOutput("t4_ovf_sticky", 64'(ovf), 64'd1);

        // Writes to A during SEND do not disturb the burst.
        for (int k = 0; k < 4; k++)
            applyStimulus(1'b1, 64'hE0 + 64'(k), 1'b1, 64'hF0 + 64'(k));
        clearStats();
        issueCommand(4);
        tick();
        tick();
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, {32'h5555_0000, 32'(k)}, 1'b0, '0);
        waitDone(40);
        tick();
        checkOutput("t5_beats", 64'(beat_seen), 64'd4);
        checkOutput("t5_a_count", 64'(a_count), 64'd3);
        checkOutput("t5_b_count", 64'(b_count), 64'd0);
        checkOutput("t5_model_count", 64'(a_count), 64'(exp_a.size()));

        // Reset at beat 2 of a len=8 burst.
        exp_a.delete();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++)
            applyStimulus(1'b1, 64'h100 + 64'(k), 1'b1, 64'h200 + 64'(k));
        clearStats();
        issueCommand(8);
        repeat (4) tick();
        checkOutput("t6_at_beat2", 64'(east_out_tvalid), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_a.delete();
        exp_b.delete();
        exp_ovf = 1'b0;
        checkOutput("t6_stage", 64'(stage_start), 64'd0);
        checkOutput("t6_valids", 64'(east_out_tvalid) + 64'(north_out_tvalid), 64'd0);
        checkOutput("t6_data", east_out_tdata | north_out_tdata, 64'd0);
        checkOutput("t6_busy", 64'(busy), 64'd0);
        checkOutput("t6_ready", 64'(cmd_ready), 64'd1);
        checkOutput("t6_counts", 64'(a_count) + 64'(b_count), 64'd0);
        checkOutput("t6_ovf", 64'(ovf), 64'(exp_ovf));
        repeat (12) tick();
        checkOutput("t6_no_done", 64'(done_seen), 64'd0);
        checkOutput("t6_beats_before_rst", 64'(beat_seen), 64'd3);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule

// File: doc/tiny_stage_feeder.md
# tiny_stage_feeder

Operand source for one row of the tiny_glut array. It buffers 64-bit operand words (4 x bf16 lanes) for the A (east) and B (north) inputs of the first basic block and replays them as valid-only streams. It drives the shared `stage_start` and holds it for a programmable drain window so results can propagate out of the row. The basic blocks have no backpressure, so this block issues a burst only when both operand FIFOs already hold the full burst.

## Interface

Parameters:
- `DEPTH`, default 16: entries per operand FIFO; power of 2, at least 2.
- `DRAIN`, default 8: cycles `stage_start` stays high after the last beat; 1..255.
- `LW`, default $clog2(DEPTH)+1: width of the length and count fields.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `a_wr_en`  in  1  push `a_wr_data` into the A FIFO.
- `a_wr_data`  in  64  A operand word.
- `a_count`  out  LW  current A FIFO occupancy.
- `b_wr_en`  in  1  push `b_wr_data` into the B FIFO.
- `b_wr_data`  in  64  B operand word.
- `b_count`  out  LW  current B FIFO occupancy.
- `cmd_valid`  in  1  burst request.
- `cmd_len`  in  LW  beats in the burst, 0..DEPTH.
- `cmd_ready`  out  1  high only in IDLE.
- `stage_start`  out  1  array stage enable.
- `east_out_tvalid`  out  1  A stream valid; connects to the row's `east_in_tvalid`.
- `east_out_tdata`  out  64  A stream data.
- `north_out_tvalid`  out  1  B stream valid; connects to `north_in_tvalid`.
- `north_out_tdata`  out  64  B stream data.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse at the end of a burst.
- `ovf`  out  1  sticky flag: a write was dropped because its FIFO was full.

## Operation

- **FIFOs.** Two independent circular FIFOs, each DEPTH x 64 bits.
  - A write while the FIFO is full is dropped and sets `ovf`. `ovf` clears only on reset.
  - Writes are accepted in every state.
  - A write and a read in the same cycle leave the count unchanged. Write-when-full plus a read in the same cycle is accepted and does not set `ovf`.
  - Pointers wrap modulo DEPTH.
- **FSM states:** IDLE, WAIT, SEND, DRAIN, DONE.
  - **IDLE:** `cmd_ready`=1. When `cmd_valid` is high, latch `cmd_len`.
    - If `cmd_len`=0, go to DONE.
    - If `cmd_len`>DEPTH, clamp it to DEPTH, then go to WAIT.
    - Otherwise go to WAIT.
  - **WAIT:** when `a_count`>=len and `b_count`>=len, go to SEND. Occupancy is evaluated on the registered counts.
  - **SEND:** one beat per cycle for len consecutive cycles.
    - Each beat pops A and B simultaneously.
    - Registered outputs per beat: `stage_start`=1, both tvalid=1, both tdata set to the FIFO heads.
    - After the len-th beat, go to DRAIN.
  - **DRAIN:** `stage_start`=1, both tvalid=0, both tdata=0, for exactly DRAIN cycles. Then go to DONE.
  - **DONE:** one cycle with `done`=1 and `stage_start`=0. Then go to IDLE.
- **Stream ordering.** Beats are emitted in FIFO order. The A and B words of a beat are the k-th entries of their respective FIFOs.
- **Outputs outside SEND/DRAIN.** `stage_start`, tvalid and tdata are all 0.

## Timing

- All outputs are registered.
- Reset values: all outputs 0, except `cmd_ready`, which is 1 from the first cycle after reset. FIFOs are emptied and pointers zeroed.
- `cmd_valid` is sampled at edge E0 with FIFOs already filled. WAIT is entered at E0.
  - The condition is met in the cycle after E0.
  - The first beat is visible after E0+2.
  - Beat k is visible after E0+2+k.
- `stage_start` is high for exactly len+DRAIN consecutive cycles.
- `done` follows the last DRAIN cycle directly.
- `cmd_ready` returns 1 in the cycle after `done`.
- len=0: `done` is high in the cycle after acceptance. `stage_start` never rises and no FIFO is popped.
- Commands are ignored while `busy`; there is no queueing.
- Reset mid-burst returns the block to IDLE on the next edge. Outputs are 0, FIFO contents are discarded, and no `done` is issued.

## Test plan

- Push A=0x0001..0x0004 and B=0x0100..0x0400 (each replicated in all four lanes), then issue cmd len=4 with DRAIN=8. Required response:
  - four consecutive beats in order, both valids high together;
  - `stage_start` high for 12 cycles;
  - one `done` pulse;
  - counts return to 0.
- Issue cmd len=3 with FIFOs empty; push A×3 first, then B×3 later. The block stays in WAIT with `stage_start`=0 until the third B write is registered, then emits 3 beats.
- len=0: `done` pulses one cycle after acceptance, with no `stage_start`, no valid, and no count change.
- Write 17 words to A with DEPTH=16: `a_count`=16, `ovf`=1, and a later len=16 burst returns the first 16 words.
- Push 4 words to each FIFO, issue len=4, and keep writing A during SEND. The burst data is unaffected, and after DONE `a_count` equals the number of words written during SEND.
- Assert `rst_n`=0 for 1 cycle at beat 2 of a len=8 burst. All outputs are 0 the next cycle, counts are 0, there is no `done`, and `cmd_ready`=1.
